// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the line pair, checks 11-bit frames,
// and folds E0/F0 prefixes into one toggle-style key event word.
module ps2_keycode_rx #(
  parameter int FILT_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_d;
  logic [FW-1:0] filt_cnt;
  logic          strobe;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          ext, ext_n, brk, brk_n;
  logic [10:0]   key_n;
  logic          ferr_n;
  logic          good;

  // Synchronizers and filter reset to the idle-high line level.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_clk <= 1'b1;
      filt_d   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      filt_d <= filt_clk;
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == FILT_LAST) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign strobe = filt_d & ~filt_clk;
  assign good   = (^{shreg, par}) & dat_s2;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      tcnt      <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      ps2_key   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      par       <= par_n;
      tcnt      <= tcnt_n;
      ext       <= ext_n;
      brk       <= brk_n;
      ps2_key   <= key_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par;
    ext_n     = ext;
    brk_n     = brk;
    key_n     = ps2_key;
    ferr_n    = 1'b0;
    tcnt_n    = (state == IDLE || strobe) ? '0 : tcnt + 1'b1;

    case (state)
      IDLE: begin
        if (strobe && !dat_s2) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (strobe) begin
          shreg_n   = {dat_s2, shreg[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (strobe) begin
          par_n   = dat_s2;
          state_n = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          state_n = IDLE;
          if (good) begin
            case (shreg)
              8'hE0: ext_n = 1'b1;
              8'hF0: brk_n = 1'b1;
              8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
              default: begin
                key_n = {~ps2_key[10], ~brk, ext, shreg};
                ext_n = 1'b0;
                brk_n = 1'b0;
              end
            endcase
          end else begin
            ferr_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A strobe coinciding with terminal count takes priority over the abort.
    if (state != IDLE && !strobe && tcnt == TO_LAST) begin
      state_n = IDLE;
      ferr_n  = 1'b1;
      ext_n   = 1'b0;
      brk_n   = 1'b0;
      tcnt_n  = '0;
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: a frame-level event model checked against the DUT every cycle,
// plus literal key values after each scenario.
module tb_ps2_keycode_rx;
  localparam int FILT_LEN = 8;
  localparam int TIMEOUT  = 300;
  localparam int HP       = 20;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  ps2_keycode_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_key(ps2_key), .frame_err(frame_err)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;
  always @(posedge Clk) edge_cnt++;

  logic [10:0] cur_key = '0;
  bit          m_ext = 0, m_brk = 0;
  bit          w_active = 0;
  int          w_t0, w_lo, w_hi, w_err;
  logic [10:0] w_new;
  int          errs, change_d, err_d, d_now;
  bit          changed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    tests++;
    if (v < lo || v > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  always @(negedge Clk) begin
    if (w_active) begin
      d_now = edge_cnt - w_t0;
      if (ps2_key !== cur_key) begin
        check("key_in_window", ps2_key, w_new);
        if (!changed) begin
          changed  = 1;
          change_d = d_now;
        end
      end
      if (frame_err) begin
        errs++;
        err_d = d_now;
      end
      if (d_now == w_hi + 1) begin
        check("key_after_frame", ps2_key, w_new);
        check("err_pulses", errs, w_err);
        if (changed) check_range("key_latency", change_d, w_lo, w_hi);
        if (errs > 0) check_range("err_latency", err_d, w_lo, w_hi);
        cur_key  = w_new;
        w_active = 0;
      end
    end else begin
      check("key_hold", ps2_key, cur_key);
      check("err_idle", frame_err, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  // Event-level rules: prefixes set flags, responses are dropped, anything else is an event.
  task automatic model_frame(input logic [7:0] b, input bit ok);
    w_new = cur_key;
    w_err = ok ? 0 : 1;
    w_lo  = FILT_LEN + 3;
    w_hi  = FILT_LEN + 5;
    if (ok) begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
        w_new = {~cur_key[10], ~m_brk, m_ext, b};
        m_ext = 0;
        m_brk = 0;
      end
    end
  endtask

  task automatic drive_bit(input logic b, input bit last);
    ps2_data = b;
    tick(HP);
    ps2_clk = 1'b0;
    if (last) begin
      w_t0     = edge_cnt;
      errs     = 0;
      changed  = 0;
      w_active = 1;
    end
    tick(HP);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    model_frame(b, !bad_par && !bad_stop);
    drive_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 0);
    drive_bit((~^b) ^ bad_par, 0);
    drive_bit(!bad_stop, 1);
    ps2_data = 1'b1;
    tick(2 * HP);
  endtask

  initial begin
    logic [7:0] partial;
    tick(4);
    check("reset_key", ps2_key, 11'h000);
    check("reset_err", frame_err, 0);
    Rst_n = 1'b1;
    tick(10);

    send_frame(8'h1C, 0, 0);
    check("lit_make_1C", ps2_key, 11'h61C);

    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    check("lit_ext_break_75", ps2_key, 11'h175);

    send_frame(8'h29, 1, 0);
    check("lit_parity_err_hold", ps2_key, 11'h175);
    send_frame(8'h29, 0, 0);
    check("lit_after_parity_29", ps2_key, 11'h629);

    // Start bit plus three data bits, then the line goes quiet.
    w_new = cur_key;
    w_err = 1;
    w_lo  = FILT_LEN + 2 + TIMEOUT;
    w_hi  = FILT_LEN + 5 + TIMEOUT;
    drive_bit(1'b0, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b0, 0);
    drive_bit(1'b1, 1);
    ps2_data = 1'b1;
    tick(TIMEOUT + 2 * HP);
    m_ext = 0;
    m_brk = 0;
    send_frame(8'h05, 0, 0);
    check("lit_after_timeout_05", ps2_key, 11'h205);

    ps2_data = 1'b0;
    tick(HP);
    ps2_clk = 1'b0;
    tick(FILT_LEN - 2);
    ps2_clk = 1'b1;
    tick(HP);
    ps2_data = 1'b1;
    tick(HP);
    send_frame(8'h16, 0, 0);
    check("lit_after_glitch_16", ps2_key, 11'h616);

    send_frame(8'hAA, 0, 0);
    check("lit_ignored_AA", ps2_key, 11'h616);
    send_frame(8'hF0, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h6B, 0, 0);
    check("lit_F0_E0_6B", ps2_key, 11'h16B);

    send_frame(8'hE0, 0, 0);
    send_frame(8'h74, 0, 1);
    send_frame(8'h74, 0, 0);
    check("lit_ext_kept_74", ps2_key, 11'h774);

    send_frame(8'hE0, 0, 0);
    partial = 8'h3A;
    drive_bit(1'b0, 0);
    for (int i = 0; i < 5; i++) drive_bit(partial[i], 0);
    Rst_n   = 1'b0;
    cur_key = '0;
    m_ext   = 0;
    m_brk   = 0;
    #1;
    check("lit_reset_mid_key", ps2_key, 11'h000);
    check("lit_reset_mid_err", frame_err, 0);
    tick(5);
    Rst_n    = 1'b1;
    ps2_data = 1'b1;
    tick(HP);
    send_frame(8'h1E, 0, 0);
    check("lit_after_reset_1E", ps2_key, 11'h61E);

    tick(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
